// File: rtl/ci_divider_pkg.sv
// Shared types and constants for the OR1420 custom-instruction divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ci_divider_pkg;

    localparam int CI_W = 32;

    // Default base custom-instruction id (even; base+1 selects the remainder)
    localparam logic [7:0] CI_DEFAULT_ID = 8'd20;

    // Step counter load value: 32 restoring steps, counted 31 down to 0
    localparam logic [4:0] CNT_LOAD = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Result select: taken from ciN[0]
    typedef enum logic {
        SEL_QUO = 1'b0,
        SEL_REM = 1'b1
    } sel_e;

endpackage

// File: rtl/ci_divider_if.sv
// Custom-instruction bus between the processor execute stage and a responder.
// Latency: n/a (wires only).
// Backpressure: processor stalls until the responder pulses ciDone; ciCke freezes the responder.
// Ports: ciStart/ciCke/ciN/ciValueA/ciValueB from master, ciDone/ciResult from slave.
interface ci_divider_if;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;

    modport master (
        output ciStart, ciCke, ciN, ciValueA, ciValueB,
        input  ciDone, ciResult
    );

    modport slave (
        input  ciStart, ciCke, ciN, ciValueA, ciValueB,
        output ciDone, ciResult
    );
endinterface

// File: rtl/ci_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_i (partial remainder), bit_i (next dividend bit), divisor_i -> rem_o, qbit_o.
module ci_divider_div_step (
    input  logic [31:0] rem_i,
    input  logic        bit_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic        qbit_o
);
    logic [32:0] partial;
    logic [31:0] diff;

    assign partial = {rem_i, bit_i};
    // When the trial is non-negative the true difference is below 2^32,
    // so the low 32 bits of the modular subtraction are exact.
    assign diff    = partial[31:0] - divisor_i;
    assign qbit_o  = (partial >= {1'b0, divisor_i});
    assign rem_o   = qbit_o ? diff : partial[31:0];
endmodule

// File: rtl/ci_divider.sv
// Iterative 32-bit unsigned divider responding to ids customId (quotient) / customId+1 (remainder).
// Latency: 33 cycles from start (1 for divide-by-zero), plus one per ciCke=0 cycle in RUN.
// Backpressure: ciCke=0 freezes progress; starts while busy are ignored.
// Ports: cpuClock, cpuReset (async, active-high), ci (slave side of ci_divider_if).
module ci_divider
    import ci_divider_pkg::*;
#(
    parameter logic [7:0] customId = CI_DEFAULT_ID
) (
    input  logic         cpuClock,
    input  logic         cpuReset,
    ci_divider_if.slave  ci
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
    logic [31:0] rem_q, rem_d;
    logic [31:0] dsr_q, dsr_d;
    sel_e        sel_q, sel_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic        selected;
    logic        accept;
    logic        div_zero;
    logic [31:0] step_rem;
    logic        step_qbit;
    logic [31:0] step_quo;

    assign selected = (ci.ciN[7:1] == customId[7:1]);
    assign accept   = (state_q == ST_IDLE) && ci.ciStart && ci.ciCke && selected;
    assign div_zero = (ci.ciValueB == 32'd0);

    ci_divider_div_step u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[31]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    assign step_quo = {dvd_q[30:0], step_qbit};

    // State register
    always_ff @(posedge cpuClock or posedge cpuReset) begin
        if (cpuReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = div_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (ci.ciCke && (cnt_q == 5'd0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next-values
    always_comb begin
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        dsr_d    = dsr_q;
        sel_d    = sel_q;
        done_d   = 1'b0;
        result_d = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dvd_d = ci.ciValueA;
                    dsr_d = ci.ciValueB;
                    sel_d = sel_e'(ci.ciN[0]);
                    rem_d = 32'd0;
                    cnt_d = CNT_LOAD;
                    if (div_zero) begin
                        // Divide-by-zero skips RUN: quotient all ones, remainder = dividend
                        done_d   = 1'b1;
                        result_d = ci.ciN[0] ? ci.ciValueA : 32'hFFFF_FFFF;
                    end
                end
            end
            ST_RUN: begin
                if (ci.ciCke) begin
                    rem_d = step_rem;
                    dvd_d = step_quo;
                    cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        // Last step: register the finished result straight into the output
                        done_d   = 1'b1;
                        result_d = (sel_q == SEL_REM) ? step_rem : step_quo;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge cpuClock or posedge cpuReset) begin
        if (cpuReset) begin
            cnt_q    <= 5'd0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Datapath registers carry no meaning outside RUN, so they are not reset
    always_ff @(posedge cpuClock) begin
        dvd_q <= dvd_d;
        rem_q <= rem_d;
        dsr_q <= dsr_d;
        sel_q <= sel_d;
    end

    assign ci.ciDone   = done_q;
    assign ci.ciResult = result_q;

endmodule

// File: tb/tb_ci_divider.sv
// Self-checking bench for ci_divider: directed cases with literal expectations plus
// a randomized stream compared every cycle against a behavioural model.
module tb_ci_divider;
    import ci_divider_pkg::*;

    localparam logic [7:0] ID = 8'd20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ci_divider_if bus();

    ci_divider #(.customId(ID)) dut (
        .cpuClock (clk),
        .cpuReset (rst),
        .ci       (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted command produces A/B or A%B after 32
    // enabled cycles (or immediately for B==0), shown for exactly one cycle.
    int          m_phase = 0;   // 0 idle, 1 busy, 2 showing result
    int          m_left  = 0;
    logic [31:0] m_res   = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_left  = 0;
        end else begin
            case (m_phase)
                2: m_phase = 0;
                1: begin
                    if (bus.ciCke) begin
                        m_left--;
                        if (m_left == 0) m_phase = 2;
                    end
                end
                default: begin
                    if (bus.ciStart && bus.ciCke && ((bus.ciN >> 1) == (ID >> 1))) begin
                        if (bus.ciValueB == 32'd0) begin
                            m_res   = bus.ciN[0] ? bus.ciValueA : 32'hFFFF_FFFF;
                            m_phase = 2;
                        end else begin
                            m_res   = bus.ciN[0] ? (bus.ciValueA % bus.ciValueB)
                                                 : (bus.ciValueA / bus.ciValueB);
                            m_phase = 1;
                            m_left  = 32;
                        end
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison, away from the active edge
    always @(negedge clk) begin
        logic        ed;
        logic [31:0] er;
        ed = (m_phase == 2);
        er = ed ? m_res : 32'd0;
        check("cyc_done", 32'(bus.ciDone), 32'(ed));
        check("cyc_result", bus.ciResult, er);
    end

    // Issue one command and measure latency to the done pulse
    task automatic run_cmd(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] n, input logic [31:0] exp_res, input int exp_lat,
                           input bit stall, input bit poke);
        int          lat;
        bit          seen;
        logic [31:0] res;
        @(posedge clk); #1;
        bus.ciStart  = 1'b1;
        bus.ciN      = n;
        bus.ciValueA = a;
        bus.ciValueB = b;
        bus.ciCke    = 1'b1;
        seen = 1'b0;
        lat  = 0;
        res  = 32'd0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(posedge clk); #1;
            lat         = i;
            bus.ciStart = poke && (i == 20);
            bus.ciCke   = !(stall && i >= 10 && i <= 14);
            @(negedge clk);
            if (bus.ciDone) begin
                seen = 1'b1;
                res  = bus.ciResult;
            end
        end
        check({nm, "_seen"}, 32'(seen), 32'd1);
        check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        check({nm, "_res"}, res, exp_res);
        @(posedge clk); #1;
        bus.ciStart = 1'b0;
        bus.ciCke   = 1'b1;
        @(negedge clk);
        check({nm, "_pulse_end"}, 32'(bus.ciDone), 32'd0);
    endtask

    // Watch for a number of cycles; count done pulses and nonzero results
    task automatic watch_quiet(input string nm, input int cycles);
        int dn;
        int nz;
        dn = 0;
        nz = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.ciDone) dn++;
            if (bus.ciResult != 32'd0) nz++;
        end
        check({nm, "_dones"}, 32'(dn), 32'd0);
        check({nm, "_nonzero"}, 32'(nz), 32'd0);
    endtask

    initial begin
        int dones;
        bus.ciStart  = 1'b0;
        bus.ciCke    = 1'b1;
        bus.ciN      = 8'd0;
        bus.ciValueA = 32'd0;
        bus.ciValueB = 32'd0;

        // Reset state
        #2;
        check("rst_done", 32'(bus.ciDone), 32'd0);
        check("rst_result", bus.ciResult, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        run_cmd("q100_7", 32'd100, 32'd7, ID, 32'd14, 33, 1'b0, 1'b0);
        run_cmd("r100_7", 32'd100, 32'd7, ID + 8'd1, 32'd2, 33, 1'b0, 1'b0);
        run_cmd("qmax_1", 32'hFFFF_FFFF, 32'd1, ID, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);
        run_cmd("r8000", 32'h8000_0000, 32'hFFFF_FFFF, ID + 8'd1, 32'h8000_0000, 33, 1'b0, 1'b0);
        run_cmd("dbz_q", 32'h1234, 32'd0, ID, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);
        run_cmd("dbz_r", 32'h1234, 32'd0, ID + 8'd1, 32'h1234, 1, 1'b0, 1'b0);
        run_cmd("stall", 32'd1000, 32'd3, ID, 32'd333, 38, 1'b1, 1'b1);

        // Reset mid-RUN, asserted between edges
        @(posedge clk); #1;
        bus.ciStart  = 1'b1;
        bus.ciN      = ID;
        bus.ciValueA = 32'd1000;
        bus.ciValueB = 32'd3;
        @(posedge clk); #1;
        bus.ciStart = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_done", 32'(bus.ciDone), 32'd0);
        check("midrst_result", bus.ciResult, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        watch_quiet("post_rst", 40);
        run_cmd("q50_5", 32'd50, 32'd5, ID, 32'd10, 33, 1'b0, 1'b0);

        // Non-matching id
        @(posedge clk); #1;
        bus.ciStart  = 1'b1;
        bus.ciN      = ID + 8'd2;
        bus.ciValueA = 32'd77;
        bus.ciValueB = 32'd7;
        @(posedge clk); #1;
        bus.ciStart = 1'b0;
        watch_quiet("nomatch", 40);

        // Randomized stream, checked every cycle against the model
        dones = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(posedge clk); #1;
            bus.ciStart = ($urandom_range(0, 3) == 0);
            bus.ciCke   = ($urandom_range(0, 7) != 0);
            r = int'($urandom_range(0, 3));
            case (r)
                0: bus.ciN = ID;
                1: bus.ciN = ID + 8'd1;
                2: bus.ciN = ID + 8'd2;
                default: bus.ciN = 8'($urandom);
            endcase
            bus.ciValueA = $urandom;
            r = int'($urandom_range(0, 7));
            if (r == 0)      bus.ciValueB = 32'd0;
            else if (r < 4)  bus.ciValueB = $urandom_range(1, 255);
            else             bus.ciValueB = $urandom;
            @(negedge clk);
            if (bus.ciDone) dones++;
        end
        check("rand_activity", 32'(dones > 20), 32'd1);

        @(posedge clk); #1;
        bus.ciStart = 1'b0;
        bus.ciCke   = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ci_divider.md
# ci_divider

Iterative 32-bit unsigned divider that acts as the responder on the OR1420 custom-instruction interface. It sits beside the processor's execute stage. It receives the two forwarded operands together with a start strobe, runs a restoring division of one bit per enabled cycle, and returns the quotient or remainder with a one-cycle done pulse. The processor stalls until that pulse arrives. Results from several custom-instruction units are OR-combined, so the result output is zero whenever the block is not signalling done.

## Interface
- customId, default 8'd20: base instruction id. Must be even. The block responds to ids customId (quotient) and customId+1 (remainder).
- cpuClock, in, 1: processor clock, rising-edge.
- cpuReset, in, 1: asynchronous, active-high reset.
- ciStart, in, 1: start strobe from the execute stage.
- ciCke, in, 1: clock enable. Low means the processor is frozen, and all internal progress halts.
- ciN, in, 8: custom-instruction id.
- ciValueA, in, 32: dividend (operand A).
- ciValueB, in, 32: divisor (operand B).
- ciDone, out, 1: result-valid pulse.
- ciResult, out, 32: quotient or remainder. Equals 0 whenever ciDone=0.

## Operation
- Select: the block is selected when ciN[7:1]==customId[7:1]. sel=ciN[0], where 0 selects the quotient and 1 selects the remainder.
- Accept: a command is accepted on a rising edge where ciStart=1, ciCke=1, the block is selected, and the state is IDLE. On accept the block captures the dividend, divisor and sel, clears the partial remainder, and loads the counter with 31.
- States:
  - IDLE.
  - RUN:
    - Each cycle with ciCke=1, the 33-bit partial remainder is {rem[31:0], dividend MSB}.
    - The trial subtraction is that value minus the divisor.
    - If the trial result is non-negative, the remainder becomes the trial result and the quotient bit is 1. Otherwise the remainder is unchanged and the quotient bit is 0.
    - The dividend/quotient register shifts left, taking in the quotient bit.
    - The counter decrements.
    - When the counter reaches 0 and that step completes, the state moves to DONE.
  - DONE: ciDone=1 and ciResult = sel ? remainder : quotient, for exactly one clock. The state then returns to IDLE unconditionally.
- Divide by zero (divisor==0 at accept): the block goes directly to DONE. The quotient is 32'hFFFFFFFF and the remainder is the dividend.
- ciCke=0 in RUN freezes the counter and all datapath registers. A DONE pulse already issued is not extended.
- ciStart while in RUN or DONE is ignored, with no restart and no corruption.
- ciStart with a non-matching ciN causes no state change.
- Reset, asynchronous and at any time including mid-RUN, forces:
  - state to IDLE;
  - the counter to 0;
  - ciDone to 0 and ciResult to 0.
- The datapath registers need not be reset.

## Timing
- Accept edge = T.
- Normal latency: RUN occupies the cycles after edges T..T+31, and ciDone is high in the cycle following edge T+32. The result is visible 33 cycles after the start cycle, provided ciCke stays 1.
- Each cycle of ciCke=0 during RUN adds exactly one cycle of latency.
- Divide-by-zero latency: ciDone is high in the cycle following edge T, i.e. 1 cycle.
- ciDone and ciResult are registered outputs with no combinational path from the inputs.
- A new command can be accepted on the edge that ends DONE's cycle, once the state is IDLE. The minimum spacing between two starts is 34 cycles.

## Structure
- The shared package holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the quotient/remainder select encoding;
  - the default id constant.
- The natural sub-module is div_step, a combinational single restoring step. It takes the 32-bit remainder, the incoming dividend bit and the divisor, and produces the new remainder and the quotient bit.
- The top level holds the FSM, the 5-bit counter, the operand/quotient shift register and the output registers.

## Test plan
- Quotient, A=100, B=7, ciN=customId, ciCke held 1 → ciDone is a single-cycle pulse 33 cycles after start, ciResult=14, and ciResult=0 in every other cycle.
- Remainder and full range, A=100, B=7, ciN=customId+1 → 2. A=32'hFFFFFFFF, B=1, quotient → 32'hFFFFFFFF. A=32'h80000000, B=32'hFFFFFFFF, remainder → 32'h80000000.
- Divide by zero, A=32'h1234, B=0 → quotient run gives 32'hFFFFFFFF after 1 cycle; remainder run gives 32'h1234 after 1 cycle.
- Stall, A=1000, B=3, ciCke=0 for 5 cycles mid-RUN → ciDone arrives 38 cycles after start with result 333. A ciStart pulse during RUN is ignored.
- Reset mid-operation, cpuReset asserted at cycle 10 of RUN, asynchronously between edges → ciDone and ciResult drop to 0 immediately and there is no later done pulse. A fresh start of 50/5 then returns 10 after 33 cycles.
- Non-matching id, ciN=customId+2 with ciStart → no ciDone in 40 cycles and ciResult=0 throughout.
